ntt_seq_ctrl: RTL

Sequencer for the polynomial-arithmetic datapath. It accepts a single start request carrying an operation code (NTT, INVNTT, MULT) and drives the `mode` and `clk_counter` inputs of the address generator for exactly one full pass. It also generates read/write enables aligned to the address generator's 6-deep write-address pipeline and signals completion with a one-cycle `done` pulse. It sits between the top-level Kyber control FSM and the NTT core.

---
 rtl/ntt_seq_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/ntt_seq_ctrl.sv
// ntt_seq_ctrl
//
// Sequencer for the polynomial-arithmetic datapath. It accepts one start
// request with an operation code and steps the address generator through one
// full pass. It also produces read/write enables that line up with the
// datapath's read-to-write pipeline, and it pulses done when the pass ends.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-low reset
//   start        operation request, sampled only while idle
//   op           operation code captured with start (0 NTT, 1 INVNTT, 2 MULT, 3 illegal)
//   mode         registered op, drives the address generator's mode input
//   clk_counter  registered pass counter, drives the address generator's counter input
//   stage        butterfly stage (clk_counter[7:5]) for NTT/INVNTT, otherwise 0
//   rd_en        datapath read/compute enable
//   wr_en        memory write enable, aligned with the address generator's w_addr
//   busy         high from the first RUN cycle through the DONE cycle
//   done         one-cycle completion pulse
module ntt_seq_ctrl #(
  parameter int NTT_LEN    = 224,
  parameter int MULT_LEN   = 140,
  parameter int PIPE_DEPTH = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] op,
  output logic [1:0] mode,
  output logic [7:0] clk_counter,
  output logic [2:0] stage,
  output logic       rd_en,
  output logic       wr_en,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_MULT    = 2'd2;
  localparam logic [1:0] OP_ILLEGAL = 2'd3;

  localparam logic [7:0] NTT_LAST   = 8'(NTT_LEN - 1);
  localparam logic [7:0] MULT_LAST  = 8'(MULT_LEN - 1);
  localparam logic [2:0] DRAIN_LAST = 3'(PIPE_DEPTH - 1);

  // MULT writes begin once the 12-cycle fill is over, then once per 4-cycle row.
  localparam logic [7:0] MULT_FILL  = 8'd12;

  state_t                state;
  state_t                next_state;
  logic                  accept;
  logic                  run_last;
  logic                  drain_last;
  logic                  is_mult;
  logic [2:0]            drain_cnt;
  logic [PIPE_DEPTH-1:0] wr_pipe;

  assign is_mult    = (mode == OP_MULT);
  assign run_last   = is_mult ? (clk_counter == MULT_LAST) : (clk_counter == NTT_LAST);
  assign drain_last = (drain_cnt == DRAIN_LAST);

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && (op != OP_ILLEGAL)) begin
          accept     = 1'b1;
          next_state = S_RUN;
        end
      end
      S_RUN: begin
        if (run_last) next_state = is_mult ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_last) next_state = S_DONE;
      end
      S_DONE: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples values from before the edge, whatever the statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      mode        <= 2'd0;
      clk_counter <= 8'd0;
      drain_cnt   <= 3'd0;
      rd_en       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      // NOTE: the delay line is a handful of flops, not a memory; it must be
      // cleared here so a reset mid-pass cannot release stale write enables.
      wr_pipe     <= '0;
    end else begin
      state <= next_state;

      // Status flags are registered from next_state so they line up with the
      // state they describe.
      rd_en <= (next_state == S_RUN);
      busy  <= (next_state != S_IDLE);
      done  <= (next_state == S_DONE);

      if (accept) begin
        mode        <= op;
        clk_counter <= 8'd0;
      end else if ((state == S_RUN) && !run_last) begin
        clk_counter <= clk_counter + 8'd1;
      end else if (next_state == S_IDLE) begin
        clk_counter <= 8'd0;
      end

      if (state == S_DRAIN) drain_cnt <= drain_cnt + 3'd1;
      else                  drain_cnt <= 3'd0;

      // The pipe runs in every mode but only feeds wr_en for NTT/INVNTT;
      // clearing it on accept keeps a previous pass from leaking into this one.
      if (accept) wr_pipe <= '0;
      else        wr_pipe <= {wr_pipe[PIPE_DEPTH-2:0], rd_en};
    end
  end

  always_comb begin
    wr_en = wr_pipe[PIPE_DEPTH-1];
    if (is_mult) begin
      wr_en = (state == S_RUN) && (clk_counter >= MULT_FILL) && (clk_counter[1:0] == 2'd3);
    end
  end

  assign stage = (!is_mult && (state != S_IDLE)) ? clk_counter[7:5] : 3'd0;

endmodule
